// File: rtl/fib_wb_pkg.sv
// rtl/fib_wb_pkg.sv - shared state encoding and register map for the Fibonacci Wishbone initiator
package fib_wb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_START,
      ST_WR_CLR,
      ST_POLL,
      ST_RD_RES,
      ST_RESP
   } fib_state_t;

   localparam logic [31:0] CTRL_OFS   = 32'h0;
   localparam logic [31:0] STATUS_OFS = 32'h4;
   localparam logic [31:0] RESULT_OFS = 32'h8;

   localparam int CTRL_ST_BIT     = 8;
   localparam int STATUS_DONE_BIT = 0;

   function automatic logic [31:0] ctrl_word(input logic [7:0] n, input logic st);
      logic [31:0] w;
      w = {24'h0, n};
      w[CTRL_ST_BIT] = st;
      return w;
   endfunction

endpackage

// File: rtl/fib_wb_xfer.sv
// rtl/fib_wb_xfer.sv - single Wishbone classic transfer engine with ack timeout
module fib_wb_xfer #(
   parameter int ACK_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] adr,
   input  logic [31:0] wdat,
   output logic        done,
   output logic        timeout,
   output logic [31:0] rdat,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i
);

   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

   logic [TW-1:0] wait_cnt;

   // An ack is only meaningful while stb is up, so a late ack after a timeout is dropped here.
   assign done    = wbm_stb_o & wbm_ack_i;
   assign timeout = wbm_stb_o & ~wbm_ack_i & (wait_cnt == TO_LAST);
   assign rdat    = wbm_dat_i;

   // Launch only from the idle bus, which guarantees a low cycle between back-to-back requests.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wbm_cyc_o <= 1'b0;
         wbm_stb_o <= 1'b0;
         wbm_we_o  <= 1'b0;
         wbm_sel_o <= 4'h0;
         wbm_adr_o <= '0;
         wbm_dat_o <= '0;
         wait_cnt  <= '0;
      end else if (!wbm_stb_o) begin
         wait_cnt <= '0;
         if (req) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= we;
            wbm_sel_o <= 4'hF;
            wbm_adr_o <= adr;
            wbm_dat_o <= we ? wdat : '0;
         end
      end else if (done || timeout) begin
         wbm_cyc_o <= 1'b0;
         wbm_stb_o <= 1'b0;
         wbm_we_o  <= 1'b0;
         wbm_sel_o <= 4'h0;
         wbm_adr_o <= '0;
         wbm_dat_o <= '0;
         wait_cnt  <= '0;
      end else begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/fib_wb_initiator.sv
// rtl/fib_wb_initiator.sv - job-level Wishbone initiator driving the Fibonacci responder
module fib_wb_initiator
   import fib_wb_pkg::*;
#(
   parameter logic [31:0] BASE_ADR    = 32'h3000_0000,
   parameter int          ACK_TIMEOUT = 16,
   parameter int          POLL_MAX    = 1024
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [7:0]  cmd_n_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_fn_o,
   output logic        rsp_err_o,
   output logic        busy_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i
);

   localparam int PW = $clog2(POLL_MAX + 1);
   localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

   fib_state_t    state;
   logic [7:0]    n_q;
   logic [PW-1:0] poll_cnt;

   logic          xfer_req;
   logic          xfer_we;
   logic [31:0]   xfer_adr;
   logic [31:0]   xfer_wdat;
   logic          xfer_done;
   logic          xfer_timeout;
   logic [31:0]   xfer_rdat;

   assign cmd_ready_o = (state == ST_IDLE);
   assign busy_o      = ~cmd_ready_o;

   // Each bus state holds its request level; the engine ignores it while a transfer is open.
   always_comb begin
      xfer_req  = 1'b1;
      xfer_we   = 1'b0;
      xfer_adr  = BASE_ADR + STATUS_OFS;
      xfer_wdat = '0;
      case (state)
         ST_WR_START: begin
            xfer_we   = 1'b1;
            xfer_adr  = BASE_ADR + CTRL_OFS;
            xfer_wdat = ctrl_word(n_q, 1'b1);
         end
         ST_WR_CLR: begin
            xfer_we   = 1'b1;
            xfer_adr  = BASE_ADR + CTRL_OFS;
            xfer_wdat = ctrl_word(n_q, 1'b0);
         end
         ST_POLL:   xfer_adr = BASE_ADR + STATUS_OFS;
         ST_RD_RES: xfer_adr = BASE_ADR + RESULT_OFS;
         default:   xfer_req = 1'b0;
      endcase
   end

   fib_wb_xfer #(
      .ACK_TIMEOUT(ACK_TIMEOUT)
   ) u_xfer (
      .clk       (wb_clk_i),
      .rst_n     (wb_rst_ni),
      .req       (xfer_req),
      .we        (xfer_we),
      .adr       (xfer_adr),
      .wdat      (xfer_wdat),
      .done      (xfer_done),
      .timeout   (xfer_timeout),
      .rdat      (xfer_rdat),
      .wbm_cyc_o (wbm_cyc_o),
      .wbm_stb_o (wbm_stb_o),
      .wbm_we_o  (wbm_we_o),
      .wbm_sel_o (wbm_sel_o),
      .wbm_adr_o (wbm_adr_o),
      .wbm_dat_o (wbm_dat_o),
      .wbm_dat_i (wbm_dat_i),
      .wbm_ack_i (wbm_ack_i)
   );

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state       <= ST_IDLE;
         n_q         <= '0;
         poll_cnt    <= '0;
         rsp_valid_o <= 1'b0;
         rsp_err_o   <= 1'b0;
         rsp_fn_o    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid_i) begin
                  n_q       <= cmd_n_i;
                  poll_cnt  <= '0;
                  rsp_err_o <= 1'b0;
                  rsp_fn_o  <= '0;
                  state     <= ST_WR_START;
               end
            end
            ST_RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            default: begin
               if (xfer_timeout) begin
                  rsp_fn_o    <= '0;
                  rsp_err_o   <= 1'b1;
                  rsp_valid_o <= 1'b1;
                  state       <= ST_RESP;
               end else if (xfer_done) begin
                  case (state)
                     ST_WR_START: state <= ST_WR_CLR;
                     ST_WR_CLR:   state <= ST_POLL;
                     ST_POLL: begin
                        if (xfer_rdat[STATUS_DONE_BIT]) begin
                           state <= ST_RD_RES;
                        end else if (poll_cnt == POLL_LAST) begin
                           rsp_fn_o    <= '0;
                           rsp_err_o   <= 1'b1;
                           rsp_valid_o <= 1'b1;
                           state       <= ST_RESP;
                        end else begin
                           poll_cnt <= poll_cnt + 1'b1;
                        end
                     end
                     ST_RD_RES: begin
                        rsp_fn_o    <= xfer_rdat;
                        rsp_err_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        state       <= ST_RESP;
                     end
                     default: state <= ST_IDLE;
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fib_wb_initiator.sv
// tb/tb_fib_wb_initiator.sv - directed and randomized jobs against a Fibonacci responder model
module tb_fib_wb_initiator;

   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam int          TO   = 16;
   localparam int          PMAX = 1024;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_n;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_fn;
   logic        rsp_err;
   logic        busy;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] adr;
   logic [31:0] dat_o;
   logic [31:0] dat_i;
   logic        ack;

   always #5 clk = ~clk;

   fib_wb_initiator #(
      .BASE_ADR   (BASE),
      .ACK_TIMEOUT(TO),
      .POLL_MAX   (PMAX)
   ) dut (
      .wb_clk_i   (clk),
      .wb_rst_ni  (rst_n),
      .cmd_valid_i(cmd_valid),
      .cmd_ready_o(cmd_ready),
      .cmd_n_i    (cmd_n),
      .rsp_valid_o(rsp_valid),
      .rsp_ready_i(rsp_ready),
      .rsp_fn_o   (rsp_fn),
      .rsp_err_o  (rsp_err),
      .busy_o     (busy),
      .wbm_cyc_o  (cyc),
      .wbm_stb_o  (stb),
      .wbm_we_o   (we),
      .wbm_sel_o  (sel),
      .wbm_adr_o  (adr),
      .wbm_dat_o  (dat_o),
      .wbm_dat_i  (dat_i),
      .wbm_ack_i  (ack)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] fib(input int n);
      logic [31:0] a, b, t;
      a = 32'd0;
      b = 32'd1;
      for (int i = 0; i < n; i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // Responder model: CTRL write with st=1 starts a job; done reads 1 from the cfg_done_after-th STATUS read.
   bit        cfg_never = 1'b0;
   bit        late_ack = 1'b0;
   int        cfg_wait = 0;
   int        cfg_done_after = 1;
   bit [7:0]  r_n = 8'd0;
   int        stat_reads = 0;
   int        wcnt = 0;
   logic      resp_ack;

   assign resp_ack = cyc & stb & !cfg_never & (wcnt == cfg_wait);
   assign ack      = resp_ack | late_ack;

   always_comb begin
      dat_i = 32'hBAD0_BAD0;
      if (resp_ack && !we) begin
         if (adr == BASE + 32'h4)
            dat_i = (stat_reads + 1 >= cfg_done_after) ? 32'hDEAD_BEE1 : 32'hDEAD_BEE0;
         else if (adr == BASE + 32'h8)
            dat_i = fib(int'(r_n));
      end
   end

   always @(posedge clk) begin
      if (cyc && stb && !ack) wcnt <= wcnt + 1;
      else                    wcnt <= 0;
      if (resp_ack) begin
         if (we && adr == BASE) begin
            r_n <= dat_o[7:0];
            if (dat_o[8]) stat_reads <= 0;
         end else if (!we && adr == BASE + 32'h4) begin
            stat_reads <= stat_reads + 1;
         end
      end
   end

   typedef struct packed {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
   } xfer_t;

   xfer_t       exp_q[$];
   logic [31:0] wr_hist[$];
   int          n_stat = 0;
   int          n_res = 0;

   function automatic xfer_t mk(input logic w, input logic [31:0] a, input logic [31:0] d);
      xfer_t x;
      x.we  = w;
      x.adr = a;
      x.dat = d;
      return x;
   endfunction

   // Bus monitor: every transfer must match the next expected one and obey the classic-cycle rules.
   bit          prev_stb = 1'b0;
   bit          prev_ack = 1'b0;
   xfer_t       held;
   int          hold_cnt = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stb <= 1'b0;
         prev_ack <= 1'b0;
      end else begin
         check("busy_vs_ready", busy, !cmd_ready);
         if (stb) begin
            check("cyc_with_stb", cyc, 1'b1);
            check("sel", sel, 4'hF);
            if (!we) check("dat_o_on_read", dat_o, 32'h0);
            if (!prev_stb) begin
               check("xfer_expected", exp_q.size() != 0, 1'b1);
               if (exp_q.size() != 0) begin
                  check("xfer_we", we, exp_q[0].we);
                  check("xfer_adr", adr, exp_q[0].adr);
                  check("xfer_dat", dat_o, exp_q[0].dat);
               end
               held     <= mk(we, adr, dat_o);
               hold_cnt <= 1;
            end else begin
               check("gap_after_ack", prev_ack, 1'b0);
               check("hold_we", we, held.we);
               check("hold_adr", adr, held.adr);
               check("hold_dat", dat_o, held.dat);
               hold_cnt <= hold_cnt + 1;
            end
            if (ack) begin
               if (exp_q.size() != 0) void'(exp_q.pop_front());
               if (we) wr_hist.push_back(dat_o);
               else if (adr == BASE + 32'h4) n_stat <= n_stat + 1;
               else if (adr == BASE + 32'h8) n_res <= n_res + 1;
            end
         end else begin
            check("cyc_without_stb", cyc, 1'b0);
            if (prev_stb && !prev_ack) begin
               check("timeout_len", hold_cnt, TO);
               if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
         end
         prev_stb <= stb;
         prev_ack <= stb & ack;
      end
   end

   logic [31:0] got_fn;
   logic        got_err;
   int          got_lat;

   task automatic finish_now();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   endtask

   task automatic run_job(input logic [7:0] n, input int done_after, input int wt,
                          input bit never, input int hold, input bit probe);
      bit          exp_err;
      logic [31:0] exp_fn;
      int          k, cnt, s_stat, s_res;
      exp_err = never || (done_after > PMAX);
      exp_fn  = exp_err ? 32'h0 : fib(int'(n));
      k       = (done_after > PMAX) ? PMAX : done_after;
      exp_q.push_back(mk(1'b1, BASE, {23'h0, 1'b1, n}));
      if (!never) begin
         exp_q.push_back(mk(1'b1, BASE, {23'h0, 1'b0, n}));
         for (int i = 0; i < k; i++) exp_q.push_back(mk(1'b0, BASE + 32'h4, 32'h0));
         if (!exp_err) exp_q.push_back(mk(1'b0, BASE + 32'h8, 32'h0));
      end
      cfg_never      = never;
      cfg_wait       = wt;
      cfg_done_after = done_after;
      s_stat         = n_stat;
      s_res          = n_res;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_n     = n;
      cnt = 0;
      while (!cmd_ready && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      check("cmd_accepted", cmd_ready, 1'b1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_n     = 8'($urandom);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!rsp_valid && cnt < 5000);
      if (!rsp_valid) begin
         check("rsp_valid_arrived", rsp_valid, 1'b1);
         finish_now();
      end else begin
         got_lat = cnt;
         got_fn  = rsp_fn;
         got_err = rsp_err;
         check("rsp_err", rsp_err, exp_err);
         check("rsp_fn", rsp_fn, exp_fn);
         if (!exp_err) check("latency", cnt, 1 + (3 + k) * (wt + 2));
         #1;
         check("exp_q_drained", exp_q.size(), 0);
         rsp_ready = 1'b0;
         if (probe) begin
            cmd_valid = 1'b1;
            cmd_n     = 8'h07;
         end
         late_ack = never;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", rsp_valid, 1'b1);
            check("hold_rsp_fn", rsp_fn, got_fn);
            check("hold_rsp_err", rsp_err, got_err);
            check("hold_cmd_ready", cmd_ready, 1'b0);
         end
         @(negedge clk);
         check("pre_hs_rsp_valid", rsp_valid, 1'b1);
         late_ack  = 1'b0;
         cmd_valid = 1'b0;
         rsp_ready = 1'b1;
         @(posedge clk);
         #1;
         rsp_ready = 1'b0;
         @(negedge clk);
         check("post_hs_cmd_ready", cmd_ready, 1'b1);
         check("post_hs_rsp_valid", rsp_valid, 1'b0);
         if (!never) check("status_reads", n_stat - s_stat, k);
         check("result_reads", n_res - s_res, exp_err ? 0 : 1);
      end
   endtask

   task automatic reset_mid_poll();
      int cnt, s;
      cfg_never      = 1'b0;
      cfg_wait       = 0;
      cfg_done_after = 1 << 30;
      exp_q.push_back(mk(1'b1, BASE, {23'h0, 1'b1, 8'd9}));
      exp_q.push_back(mk(1'b1, BASE, {23'h0, 1'b0, 8'd9}));
      for (int i = 0; i < 60; i++) exp_q.push_back(mk(1'b0, BASE + 32'h4, 32'h0));
      s = n_stat;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_n     = 8'd9;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!((n_stat - s >= 3) && stb) && cnt < 200);
      check("reached_poll", (n_stat - s >= 3) && stb, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_cyc", cyc, 1'b0);
      check("rst_stb", stb, 1'b0);
      check("rst_we", we, 1'b0);
      check("rst_adr", adr, 32'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_cmd_ready", cmd_ready, 1'b1);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("post_rst_no_rsp", rsp_valid, 1'b0);
         check("post_rst_no_stb", stb, 1'b0);
      end
   endtask

   initial begin
      #600000;
      check("watchdog", 1'b0, 1'b1);
      finish_now();
   end

   initial begin
      int ws;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_n     = 8'h0;
      rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_cyc", cyc, 1'b0);
      check("reset_stb", stb, 1'b0);
      check("reset_we", we, 1'b0);
      check("reset_sel", sel, 4'h0);
      check("reset_adr", adr, 32'h0);
      check("reset_dat", dat_o, 32'h0);
      check("reset_rsp_valid", rsp_valid, 1'b0);
      check("reset_rsp_err", rsp_err, 1'b0);
      check("reset_rsp_fn", rsp_fn, 32'h0);
      check("reset_busy", busy, 1'b0);
      check("reset_cmd_ready", cmd_ready, 1'b1);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      ws = wr_hist.size();
      run_job(8'd10, 3, 0, 1'b0, 0, 1'b0);
      check("n10_fn", got_fn, 32'd55);
      check("n10_err", got_err, 1'b0);
      check("n10_wr_start", wr_hist[ws], 32'h10A);
      check("n10_wr_clr", wr_hist[ws+1], 32'h00A);

      run_job(8'd0, 1, 0, 1'b0, 0, 1'b0);
      check("n0_fn", got_fn, 32'h0);
      check("n0_latency", got_lat, 9);

      run_job(8'd47, 2, 1, 1'b0, 1, 1'b0);
      check("n47_fn", got_fn, 32'hB11924E1);
      check("n47_err", got_err, 1'b0);

      run_job(8'd3, 1, 0, 1'b1, 4, 1'b0);
      check("noack_err", got_err, 1'b1);
      check("noack_fn", got_fn, 32'h0);

      run_job(8'd4, PMAX + 1, 0, 1'b0, 0, 1'b0);
      check("pollmax_err", got_err, 1'b1);
      run_job(8'd6, PMAX, 0, 1'b0, 0, 1'b0);
      check("poll_last_fn", got_fn, 32'd8);

      run_job(8'd12, 2, 2, 1'b0, 20, 1'b1);
      check("hold_fn", got_fn, 32'd144);

      reset_mid_poll();
      run_job(8'd5, 1, 0, 1'b0, 0, 1'b0);
      check("after_rst_fn", got_fn, 32'd5);

      for (int j = 0; j < 12; j++)
         run_job(8'($urandom_range(0, 60)), int'($urandom_range(1, 5)),
                 int'($urandom_range(0, 3)), 1'b0, int'($urandom_range(0, 3)), 1'(j % 2));

      finish_now();
   end

endmodule

// File: doc/fib_wb_initiator.md
FIB_WB_INITIATOR -- requirements
Module: fib_wb_initiator

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- BASE_ADR, 32'h3000_0000, base address of the Fibonacci Wishbone responder.
- ACK_TIMEOUT, 16, maximum cycles waited for wbm_ack_i per transfer.
- POLL_MAX, 1024, maximum STATUS reads per job.
REQ-002 SHALL use one clock and an asynchronous, active-low reset. Ports (name, direction, width, meaning):
- wb_clk_i, in, 1, sole clock.
- wb_rst_ni, in, 1, asynchronous active-low reset.
- cmd_valid_i, in, 1, job request.
- cmd_ready_o, out, 1, job accepted this cycle.
- cmd_n_i, in, 8, Fibonacci index.
- rsp_valid_o, out, 1, result available.
- rsp_ready_i, in, 1, result consumed.
- rsp_fn_o, out, 32, F(n).
- rsp_err_o, out, 1, job failed (timeout).
- busy_o, out, 1, job in progress.
- wbm_cyc_o, wbm_stb_o, wbm_we_o, out, 1 each, Wishbone classic strobes.
- wbm_sel_o, out, 4, byte selects.
- wbm_adr_o, out, 32, address.
- wbm_dat_o, out, 32, write data.
- wbm_dat_i, in, 32, read data.
- wbm_ack_i, in, 1, transfer acknowledge.

Function
REQ-003 SHALL be the Wishbone initiator for the Fibonacci responder register map:
- CTRL at BASE_ADR+0x0: bits [7:0] = n, bit 8 = st.
- STATUS at BASE_ADR+0x4: bit 0 = done.
- RESULT at BASE_ADR+0x8: fn[31:0].
REQ-004 SHALL accept a job only in IDLE; cmd_ready_o = 1 iff state is IDLE; handshake completes when cmd_valid_i && cmd_ready_o; cmd_n_i is latched on that cycle.
REQ-005 SHALL sequence the FSM IDLE -> WR_START -> WR_CLR -> POLL -> RD_RES -> RESP -> IDLE:
- WR_START writes CTRL = {st=1, n}.
- WR_CLR writes CTRL = {st=0, n}.
- POLL reads STATUS, repeating until bit 0 = 1.
- RD_RES reads RESULT.
REQ-006 SHALL issue single classic cycles:
- cyc/stb/we/adr/dat/sel are asserted together and held stable until the ack cycle.
- On the ack cycle, read data is captured and cyc/stb drop on the next edge.
- cyc/stb stay low for at least one cycle between transfers.
- sel is always 4'hF.
- we = 0 on reads, and wbm_dat_o = 0 during reads.
REQ-007 SHALL count cycles from stb assertion. If ACK_TIMEOUT cycles elapse with no ack, it SHALL drop cyc/stb and go to RESP with rsp_err_o = 1 and rsp_fn_o = 0.
REQ-008 SHALL go to RESP with rsp_err_o = 1 and rsp_fn_o = 0 if POLL_MAX STATUS reads return done = 0.
REQ-009 SHALL, in RESP, hold rsp_valid_o = 1 with stable rsp_fn_o and rsp_err_o until rsp_ready_i = 1. On that cycle it SHALL return to IDLE, so cmd_ready_o = 1 on the following cycle.
REQ-010 SHALL ignore an ack arriving when stb is low; a late ack after a timeout has no effect.
REQ-011 SHALL drive busy_o = 1 in every state except IDLE.
REQ-012 SHALL take at least 4 transfers per job: 2 writes, at least 1 poll, and 1 result read. With a zero-wait-state responder and done on the first poll, cmd accept to rsp_valid_o is 9 cycles.

Reset
REQ-013 SHALL, while wb_rst_ni = 0, immediately force:
- state = IDLE;
- wbm_cyc_o, wbm_stb_o, wbm_we_o = 0;
- wbm_adr_o, wbm_dat_o, wbm_sel_o = 0;
- rsp_valid_o, rsp_err_o, busy_o = 0;
- rsp_fn_o = 0;
- all counters = 0.
cmd_ready_o follows IDLE (1).
REQ-014 SHALL, on reset mid-job, abandon the job with no response and release the bus asynchronously.

Structure
REQ-015 SHALL place the FSM state enum, the CTRL/STATUS/RESULT offsets, the CTRL_ST_BIT (8) and STATUS_DONE_BIT (0) constants in the shared package fib_wb_pkg.
REQ-016 SHALL use one sub-module, fib_wb_xfer: a single-transfer engine with a timeout counter. Inputs: req, we, adr, wdat. Outputs: done, timeout, rdat.

Verification
REQ-017 Bench SHALL cover, against a Fibonacci responder model:
- n=10, zero-wait ack, done on 3rd poll -> rsp_fn_o=55, rsp_err_o=0; bus trace shows writes 0x10A and 0x00A to CTRL, 3 STATUS reads, 1 RESULT read.
- n=0 -> rsp_fn_o=0; n=47 -> rsp_fn_o=32'hB11924E1; both with err=0.
- Responder never acks -> cyc/stb drop after 16 cycles; rsp_valid_o=1, rsp_err_o=1, rsp_fn_o=0.
- done never set -> after 1024 polls, rsp_err_o=1.
- rsp_ready_i held low 20 cycles -> rsp_valid_o and rsp_fn_o stable; cmd_ready_o=0 and a new cmd_valid_i is not accepted until the response handshake completes.
- wb_rst_ni pulsed low during POLL -> cyc/stb low within the same cycle; no rsp_valid_o; next job with n=5 returns 5.
